torus_inject_queue: RTL and testbench

Injection queue between a processing element and the `torus_switch` client port. It accepts messages from the PE on a valid/ready handshake and buffers them in a small FIFO. It presents the head entry on the switch's `i_v/i_x/i_y/i_data` inputs and pops it on the switch's `i_ack`. This decouples PE traffic bursts from deflection-free injection slots in the torus.

---
 rtl/torus_noc_pkg.sv | 31 +++
 rtl/torus_fifo_mem.sv | 33 +++
 rtl/torus_inject_queue.sv | 128 ++++++++++++
 tb/tb_torus_inject_queue.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/torus_noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : torus_noc_pkg
// Brief    : Shared message layout for the torus NoC injection path.
//            A message is packed as {x, y, data}.
// Revision : 1.0 - initial release
// ============================================================================
package torus_noc_pkg;

  // Default field widths
  localparam int X_W_DEF = 2;
  localparam int Y_W_DEF = 2;
  localparam int D_W_DEF = 32;

  // Packed message width for the default configuration
  localparam int MSG_W = X_W_DEF + Y_W_DEF + D_W_DEF;

  // Message layout for the default configuration
  typedef struct packed {
    logic [X_W_DEF-1:0] x;
    logic [Y_W_DEF-1:0] y;
    logic [D_W_DEF-1:0] data;
  } msg_t;

  // Packed message width for an arbitrary field configuration
  function automatic int msg_w(input int xw, input int yw, input int dw);
    return xw + yw + dw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/torus_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : torus_fifo_mem
// Brief    : DEPTH x W register array. One synchronous write port and one
//            asynchronous read port. Storage is not reset; the consumer masks
//            the read data while the queue is empty.
// Revision : 1.0 - initial release
// ============================================================================
module torus_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Write the addressed entry on an accepted push
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/torus_inject_queue.sv
`default_nettype none
// ============================================================================
// Module   : torus_inject_queue
// Brief    : PE-to-switch injection FIFO. It accepts messages on a valid/ready
//            handshake, presents the head to the switch client port and pops
//            it on i_ack. There is no fall-through path and no combinational
//            path from any input to any output.
//            Define TORUS_INJECT_STATS_EN to build the saturating stall/sent
//            counters. When it is undefined, both counter ports read 0.
// Revision : 1.0 - initial release
// ============================================================================
module torus_inject_queue
  import torus_noc_pkg::*;
#(
  parameter int X_W   = 2,
  parameter int Y_W   = 2,
  parameter int D_W   = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pe_v,
  input  logic [X_W-1:0]           pe_x,
  input  logic [Y_W-1:0]           pe_y,
  input  logic [D_W-1:0]           pe_data,
  output logic                     pe_rdy,
  output logic                     i_v,
  output logic [X_W-1:0]           i_x,
  output logic [Y_W-1:0]           i_y,
  output logic [D_W-1:0]           i_data,
  input  logic                     i_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         sent_cnt
);

  localparam int c_msg_w = msg_w(X_W, Y_W, D_W);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_push;
  logic               w_pop;
  logic [c_msg_w-1:0] w_wdata;
  logic [c_msg_w-1:0] w_rdata;

  // Ready depends only on the registered count, so a pop in the full cycle
  // cannot admit a push in that same cycle.
  assign pe_rdy  = (r_count != c_full);
  assign empty   = (r_count == '0);
  assign i_v     = !empty;
  assign count   = r_count;
  assign w_push  = pe_v && pe_rdy;
  assign w_pop   = i_v && i_ack;
  assign w_wdata = {pe_x, pe_y, pe_data};

  torus_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (c_msg_w)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wptr),
    .wdata (w_wdata),
    .raddr (r_rptr),
    .rdata (w_rdata)
  );

  // Mask the head fields while empty so stale or uninitialised storage never
  // reaches the switch.
  assign i_x    = i_v ? w_rdata[c_msg_w-1 -: X_W]     : '0;
  assign i_y    = i_v ? w_rdata[D_W+Y_W-1 -: Y_W]     : '0;
  assign i_data = i_v ? w_rdata[D_W-1:0]              : '0;

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

`ifdef TORUS_INJECT_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_sent_cnt;

  // Saturating counters for stalled head cycles and accepted messages
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_sent_cnt  <= '0;
    end else begin
      if (i_v && !i_ack && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_pop && (r_sent_cnt != '1)) begin
        r_sent_cnt <= r_sent_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign sent_cnt  = r_sent_cnt;
`else
  assign stall_cnt = '0;
  assign sent_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_torus_inject_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_torus_inject_queue
// Brief    : Directed self-checking bench for torus_inject_queue (DEPTH=4).
//            Tracks the statistics counters according to whether
//            TORUS_INJECT_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_torus_inject_queue;

`ifdef TORUS_INJECT_STATS_EN
  localparam bit c_stats = 1'b1;
`else
  localparam bit c_stats = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pe_v;
  logic [1:0]  pe_x;
  logic [1:0]  pe_y;
  logic [31:0] pe_data;
  logic        pe_rdy;
  logic        i_v;
  logic [1:0]  i_x;
  logic [1:0]  i_y;
  logic [31:0] i_data;
  logic        i_ack;
  logic [2:0]  count;
  logic        empty;
  logic [15:0] stall_cnt;
  logic [15:0] sent_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference queue of {x, y, data} plus expected raw counter values
  logic [35:0] q[$];
  int          m_stall;
  int          m_sent;

  always #5 clk = ~clk;

  torus_inject_queue #(
    .X_W   (2),
    .Y_W   (2),
    .D_W   (32),
    .DEPTH (4),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pe_v      (pe_v),
    .pe_x      (pe_x),
    .pe_y      (pe_y),
    .pe_data   (pe_data),
    .pe_rdy    (pe_rdy),
    .i_v       (i_v),
    .i_x       (i_x),
    .i_y       (i_y),
    .i_data    (i_data),
    .i_ack     (i_ack),
    .count     (count),
    .empty     (empty),
    .stall_cnt (stall_cnt),
    .sent_cnt  (sent_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected value of a statistics port given its raw event count
  function automatic logic [63:0] st(input int v);
    return c_stats ? 64'(v) : 64'd0;
  endfunction

  // Advance one clock: update the reference from the current inputs, then
  // settle 1 time unit past the rising edge.
  task automatic tick();
    bit mpush, mpop, mstall;
    mpush  = pe_v && (q.size() != 4);
    mpop   = (q.size() != 0) && i_ack;
    mstall = (q.size() != 0) && !i_ack;
    if (rst) begin
      q.delete();
      m_stall = 0;
      m_sent  = 0;
    end else begin
      if (mstall) m_stall++;
      if (mpop) begin
        void'(q.pop_front());
        m_sent++;
      end
      if (mpush) q.push_back({pe_x, pe_y, pe_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] x, input logic [1:0] y, input logic [31:0] d);
    pe_v = v; pe_x = x; pe_y = y; pe_data = d;
  endtask

  task automatic check_head(input string tag);
    logic [35:0] h;
    h = (q.size() != 0) ? q[0] : 36'd0;
    check({tag, ".i_v"},    64'(i_v),    64'(q.size() != 0));
    check({tag, ".i_x"},    64'(i_x),    64'(h[35:34]));
    check({tag, ".i_y"},    64'(i_y),    64'(h[33:32]));
    check({tag, ".i_data"}, 64'(i_data), 64'(h[31:0]));
    check({tag, ".count"},  64'(count),  64'(q.size()));
  endtask

  initial begin
    rst = 1'b1; i_ack = 1'b0;
    drive(1'b0, 2'd0, 2'd0, 32'd0);
    q.delete(); m_stall = 0; m_sent = 0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst.pe_rdy", 64'(pe_rdy), 64'd1);
    check("rst.i_v",    64'(i_v),    64'd0);
    check("rst.empty",  64'(empty),  64'd1);
    check("rst.count",  64'(count),  64'd0);
    check("rst.i_x",    64'(i_x),    64'd0);
    check("rst.i_y",    64'(i_y),    64'd0);
    check("rst.i_data", 64'(i_data), 64'd0);
    check("rst.stall",  64'(stall_cnt), 64'd0);
    check("rst.sent",   64'(sent_cnt),  64'd0);

    // Single push, then five stalled cycles with a stable head
    drive(1'b1, 2'd1, 2'd2, 32'hA5A5_0001);
    tick();
    drive(1'b0, 2'd0, 2'd0, 32'd0);
    check("p1.i_v",    64'(i_v),    64'd1);
    check("p1.i_x",    64'(i_x),    64'd1);
    check("p1.i_y",    64'(i_y),    64'd2);
    check("p1.i_data", 64'(i_data), 64'hA5A5_0001);
    check("p1.count",  64'(count),  64'd1);
    check("p1.empty",  64'(empty),  64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall.i_data", 64'(i_data), 64'hA5A5_0001);
    end
    check("stall.stall_cnt", 64'(stall_cnt), st(5));
    check("stall.sent_cnt",  64'(sent_cnt),  st(0));
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    check("pop1.count", 64'(count),    64'd0);
    check("pop1.sent",  64'(sent_cnt), st(1));

    // Fill to DEPTH, ignored fifth push, pop-only in the full cycle
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 2'(3 - k), 32'h1000 + 32'(k));
      tick();
    end
    check("full.count",  64'(count),  64'd4);
    check("full.pe_rdy", 64'(pe_rdy), 64'd0);
    drive(1'b1, 2'd3, 2'd3, 32'hDEAD_0005);
    tick();
    check("full.ign.count", 64'(count), 64'd4);
    check_head("full.ign");
    drive(1'b1, 2'd3, 2'd3, 32'hBEEF_0006);
    i_ack = 1'b1;
    tick();
    drive(1'b0, 2'd0, 2'd0, 32'd0);
    i_ack = 1'b0;
    check("fullpop.count",  64'(count),  64'd3);
    check("fullpop.i_data", 64'(i_data), 64'h1001);
    check("fullpop.stall",  64'(stall_cnt), st(m_stall));
    check("fullpop.sent",   64'(sent_cnt),  st(2));

    // Reset with three entries queued discards them
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst.i_v",    64'(i_v),       64'd0);
    check("mrst.count",  64'(count),     64'd0);
    check("mrst.pe_rdy", 64'(pe_rdy),    64'd1);
    check("mrst.i_data", 64'(i_data),    64'd0);
    check("mrst.stall",  64'(stall_cnt), 64'd0);
    check("mrst.sent",   64'(sent_cnt),  64'd0);
    drive(1'b1, 2'd2, 2'd1, 32'hCAFE_0005);
    tick();
    drive(1'b0, 2'd0, 2'd0, 32'd0);
    check("postrst.i_x",    64'(i_x),    64'd2);
    check("postrst.i_y",    64'(i_y),    64'd1);
    check("postrst.i_data", 64'(i_data), 64'hCAFE_0005);
    check("postrst.count",  64'(count),  64'd1);

    // Clean start, fill 2, then 10 cycles of simultaneous push and pop
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 2; n++) begin
      drive(1'b1, 2'(n), 2'(n + 1), 32'h2000 + 32'(n));
      tick();
    end
    i_ack = 1'b1;
    for (int n = 2; n < 12; n++) begin
      check("stream.i_data", 64'(i_data), 64'h2000 + 64'(n - 2));
      drive(1'b1, 2'(n), 2'(n + 1), 32'h2000 + 32'(n));
      tick();
      check("stream.count", 64'(count), 64'd2);
    end
    check("stream.sent", 64'(sent_cnt), st(10));
    check_head("stream.head");

    // Drain, then an ack with nothing queued
    drive(1'b0, 2'd0, 2'd0, 32'd0);
    tick(); tick();
    i_ack = 1'b0;
    check("drain.empty", 64'(empty), 64'd1);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    check("idleack.count", 64'(count),    64'd0);
    check("idleack.sent",  64'(sent_cnt), st(12));
    check("idleack.stall", 64'(stall_cnt), st(m_stall));
    // Pointers stayed aligned: the next push lands as the head
    drive(1'b1, 2'd3, 2'd0, 32'h3000_0001);
    tick();
    drive(1'b0, 2'd0, 2'd0, 32'd0);
    check_head("idleack.push");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
